// File: rtl/fifo_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_frame_pkg
//  Description : Definitions shared by the write-side framer and the
//                read-side deframer of the asynchronous FIFO link.
//                Frame layout on the FIFO:
//                    SYNC, seq, payload[0..N-1], csum
//                where csum = seq ^ payload[0] ^ ... ^ payload[N-1].
//  Contents    : framer state enum, default sync byte, header length,
//                checksum accumulation step.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_frame_pkg;

    // Default FIFO byte width.
    localparam int DSIZE_DEFAULT = 8;

    // Default frame sync byte.
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Bytes ahead of the payload: SYNC and seq.
    localparam int HDR_LEN = 2;

    // Framer states. Encoding is fixed so the deframer can decode a
    // captured state value consistently.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_SEQ  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } frame_state_e;

    // One checksum accumulation step. The accumulator is seeded with the
    // sequence number and folds in every payload byte.
    function automatic logic [7:0] csum_step(input logic [7:0] acc,
                                             input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage : fifo_frame_pkg
`default_nettype wire

// File: rtl/fifo_wr_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_framer_if
//  Description : Handshake bundle around the write-side framer: the
//                producer byte stream (s_*) and the FIFO write port
//                (wfull / winc / wdata).
//  Signals     : s_data  - payload byte from the producer
//                s_valid - s_data / s_last are valid
//                s_last  - current byte ends the packet
//                s_ready - framer consumes the byte this edge
//                wfull   - FIFO full flag (registered in the FIFO)
//                winc    - FIFO write strobe
//                wdata   - FIFO write data
//  Modports    : slave  - the framer (consumes stream, drives FIFO port)
//                master - the environment (producer + FIFO)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_framer_if
    import fifo_frame_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEFAULT
);

    logic [DSIZE-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic             wfull;
    logic             winc;
    logic [DSIZE-1:0] wdata;

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        input  wfull,
        output s_ready,
        output winc,
        output wdata
    );

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        output wfull,
        input  s_ready,
        input  winc,
        input  wdata
    );

endinterface : fifo_wr_framer_if
`default_nettype wire

// File: rtl/fifo_wr_framer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_framer
//  Description : Write-domain framing stage in front of the async FIFO.
//                Wraps every producer packet as SYNC, seq, payload, csum
//                and writes it into the FIFO, throttled by wfull.
//  Parameters  : DSIZE - byte width, must equal the FIFO data width and
//                        the DSIZE of the connected interface
//                SYNC  - frame sync byte
//                CNTW  - width of frame_cnt
//  Ports       : wclk      - write-domain clock, rising edge
//                wrst_n    - asynchronous active-low reset
//                bus       - producer stream + FIFO write port (slave)
//                frame_cnt - completed frames, wraps
//                busy      - framer is not idle (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_framer
    import fifo_frame_pkg::*;
#(
    parameter int               DSIZE = DSIZE_DEFAULT,
    parameter logic [DSIZE-1:0] SYNC  = DSIZE'(SYNC_DEFAULT),
    parameter int               CNTW  = 16
) (
    input  logic             wclk,
    input  logic             wrst_n,
    fifo_wr_framer_if.slave  bus,
    output logic [CNTW-1:0]  frame_cnt,
    output logic             busy
);

    localparam logic [DSIZE-1:0] c_seq_one = DSIZE'(1);
    localparam logic [CNTW-1:0]  c_cnt_one = CNTW'(1);

    frame_state_e     r_state;
    logic [DSIZE-1:0] r_csum;
    logic [DSIZE-1:0] r_seq;
    logic [CNTW-1:0]  r_frame_cnt;
    logic             r_busy;

    logic             w_winc;
    logic             w_s_ready;
    logic [DSIZE-1:0] w_wdata;

    // ------------------------------------------------------------------
    // Output mux. winc already folds in !wfull, so every strobe is a
    // write the FIFO accepts; the FSM below uses w_winc as "accepted".
    // ------------------------------------------------------------------
    always_comb begin
        w_winc    = 1'b0;
        w_s_ready = 1'b0;
        w_wdata   = '0;
        case (r_state)
            ST_SYNC: begin
                w_wdata = SYNC;
                w_winc  = !bus.wfull;
            end
            ST_SEQ: begin
                w_wdata = r_seq;
                w_winc  = !bus.wfull;
            end
            ST_DATA: begin
                // Pass-through: the producer byte goes straight to the
                // FIFO, so consumption and the FIFO write coincide.
                w_wdata   = bus.s_data;
                w_winc    = bus.s_valid && !bus.wfull;
                w_s_ready = !bus.wfull;
            end
            ST_CSUM: begin
                w_wdata = r_csum;
                w_winc  = !bus.wfull;
            end
            default: begin
                w_winc    = 1'b0;
                w_s_ready = 1'b0;
                w_wdata   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Framing FSM with checksum, sequence and frame counters. busy is
    // updated together with the state so it mirrors (state != IDLE).
    // ------------------------------------------------------------------
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state     <= ST_IDLE;
            r_csum      <= '0;
            r_seq       <= '0;
            r_frame_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Detect only; the first byte is consumed in DATA.
                    if (bus.s_valid) begin
                        r_state <= ST_SYNC;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (w_winc) begin
                        r_csum  <= '0;
                        r_state <= ST_SEQ;
                    end
                end
                ST_SEQ: begin
                    if (w_winc) begin
                        r_csum  <= r_seq;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_winc) begin
                        r_csum <= r_csum ^ bus.s_data;
                        if (bus.s_last) begin
                            r_state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_winc) begin
                        r_seq       <= r_seq + c_seq_one;
                        r_frame_cnt <= r_frame_cnt + c_cnt_one;
                        // A packet already waiting starts its SYNC on
                        // the very next cycle, giving gap-free frames.
                        if (bus.s_valid) begin
                            r_state <= ST_SYNC;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.winc    = w_winc;
    assign bus.wdata   = w_wdata;
    assign bus.s_ready = w_s_ready;
    assign frame_cnt   = r_frame_cnt;
    assign busy        = r_busy;

endmodule : fifo_wr_framer
`default_nettype wire

// File: tb/tb_fifo_wr_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_framer
//  Description : Self-checking bench for fifo_wr_framer. Payloads are
//                random or fixed; the expected FIFO byte stream is built
//                from the frame layout (SYNC, seq, payload, XOR csum) and
//                compared with the writes captured at the FIFO port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_framer;
    import fifo_frame_pkg::*;

    typedef logic [7:0] byte_q_t [$];

    logic        wclk;
    logic        wrst_n;
    logic [15:0] frame_cnt;
    logic        busy;

    fifo_wr_framer_if #(.DSIZE(8)) bus ();

    fifo_wr_framer #(
        .DSIZE (8),
        .SYNC  (8'hA5),
        .CNTW  (16)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .bus       (bus),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    // Monitor state (written only by the monitor).
    int         cyc       = 0;
    int         viol      = 0;
    int         ready_cnt = 0;
    int         idle_cnt  = 0;
    logic [7:0] obs_q [$];
    int         obs_cyc [$];

    // Reference model.
    logic [7:0] exp_q [$];
    int         exp_seq    = 0;
    int         exp_frames = 0;

    // wfull generator control.
    int   full_mode  = 0;   // 0 off, 1 random, 2 alternate, 3 forced
    logic full_force = 1'b0;

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    always @(posedge wclk) begin
        #1;
        case (full_mode)
            1:       bus.wfull = ($urandom_range(0, 2) == 0);
            2:       bus.wfull = ~bus.wfull;
            3:       bus.wfull = full_force;
            default: bus.wfull = 1'b0;
        endcase
    end

    // Inputs only change 1 time unit after a rising edge, so values seen
    // on the falling edge are the ones the next rising edge acts on.
    always @(negedge wclk) begin
        cyc++;
        if (wrst_n === 1'b1) begin
            if (bus.winc === 1'b1) begin
                obs_q.push_back(bus.wdata);
                obs_cyc.push_back(cyc);
            end
            if (bus.winc === 1'b1 && bus.wfull === 1'b1) viol++;
            if (bus.s_ready === 1'b1 && bus.wfull === 1'b1) viol++;
            if (bus.s_ready === 1'b1) ready_cnt++;
            if (busy === 1'b0) idle_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- model ----------------
    function automatic void add_frame(input byte_q_t p);
        logic [7:0] c;
        c = 8'(exp_seq);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(exp_seq));
        foreach (p[i]) begin
            exp_q.push_back(p[i]);
            c = c ^ p[i];
        end
        exp_q.push_back(c);
        exp_seq    = (exp_seq + 1) % 256;
        exp_frames = exp_frames + 1;
    endfunction

    function automatic int first_diff(input int base);
        int n;
        n = obs_q.size() - base;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= n) return i;
            if (obs_q[base + i] !== exp_q[i]) return i;
        end
        if (n != exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    function automatic logic [7:0] obs_at(input int i);
        if (i >= 0 && i < obs_q.size()) return obs_q[i];
        return 8'hxx;
    endfunction

    function automatic logic [7:0] exp_at(input int i);
        if (i >= 0 && i < exp_q.size()) return exp_q[i];
        return 8'hxx;
    endfunction

    function automatic byte_q_t rand_payload(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    // ---------------- drivers ----------------
    task automatic send_packet(input byte_q_t p, input bit hold_valid);
        for (int i = 0; i < p.size(); i++) begin
            int n;
            bit done;
            n    = 0;
            done = 1'b0;
            bus.s_valid = 1'b1;
            bus.s_data  = p[i];
            bus.s_last  = (i == p.size() - 1);
            while (!done) begin
                @(negedge wclk);
                done = (bus.s_ready === 1'b1);
                @(posedge wclk);
                #1;
                n++;
                if (!done && n > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: byte %0d not consumed, got s_ready=%b want 1", i, bus.s_ready);
                    bus.s_valid = 1'b0;
                    bus.s_last  = 1'b0;
                    return;
                end
            end
        end
        if (!hold_valid) begin
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge wclk);
            n++;
        end while (busy !== 1'b0 && n < 3000);
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b want 0", busy);
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst_n      = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        exp_seq    = 0;
        exp_frames = 0;
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        wrst_n      = 1'b1;
        #2;
        wrst_n = 1'b0;
        #1;
        checks++; if (bus.winc !== 1'b0)  begin errors++; $display("FAIL rst_winc: got %b want 0", bus.winc); end
        checks++; if (bus.wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %h want 00", bus.wdata); end
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
        #30;
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        checks++; if (busy !== 1'b0 || bus.winc !== 1'b0) begin
            errors++; $display("FAIL idle_after_rst: got busy=%b winc=%b want 0 0", busy, bus.winc);
        end
    endtask

    task automatic test_basic();
        byte_q_t p;
        int base, rb, ib, d;
        base = obs_q.size();
        rb   = ready_cnt;
        ib   = idle_cnt;
        exp_q.delete();
        p = '{8'h01, 8'h02, 8'h04};
        add_frame(p);
        send_packet(p, 1'b0);
        wait_idle();
        d = first_diff(base);
        checks++; if (d >= 0) begin errors++;
            $display("FAIL basic_stream: idx %0d got %h want %h (got %0d bytes, want %0d)", d, obs_at(base + d), exp_at(d), obs_q.size() - base, exp_q.size());
        end
        checks++; if (obs_at(base + 5) !== 8'h07) begin errors++; $display("FAIL basic_csum: got %h want 07", obs_at(base + 5)); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
        checks++; if (ready_cnt - rb != 3) begin errors++; $display("FAIL basic_ready_cycles: got %0d want 3", ready_cnt - rb); end
        checks++; if (obs_q.size() - base < 6 || obs_cyc[base + 5] - obs_cyc[base] != 5) begin errors++;
            $display("FAIL basic_contiguous: got %0d writes not in 6 consecutive cycles, want 6", obs_q.size() - base);
        end
        // One detect cycle in IDLE and one cycle after CSUM before idle.
        checks++; if (idle_cnt - ib != 2) begin errors++; $display("FAIL basic_busy_idle_cycles: got %0d want 2", idle_cnt - ib); end
    endtask

    task automatic test_back_to_back();
        byte_q_t p;
        int base, ib, d, n;
        bit ok;
        do_reset();
        base = obs_q.size();
        ib   = idle_cnt;
        p = '{8'h01, 8'h02, 8'h04};
        add_frame(p);
        send_packet(p, 1'b1);
        p = '{8'h10};
        add_frame(p);
        send_packet(p, 1'b1);
        for (int k = 0; k < 3; k++) begin
            p = rand_payload($urandom_range(1, 6));
            add_frame(p);
            send_packet(p, k < 2);
        end
        wait_idle();
        d = first_diff(base);
        checks++; if (d >= 0) begin errors++;
            $display("FAIL b2b_stream: idx %0d got %h want %h (got %0d bytes, want %0d)", d, obs_at(base + d), exp_at(d), obs_q.size() - base, exp_q.size());
        end
        checks++; if (obs_at(base + 6) !== 8'hA5 || obs_at(base + 7) !== 8'h01 || obs_at(base + 9) !== 8'h11) begin errors++;
            $display("FAIL b2b_frame2: got %h,%h,%h want a5,01,11", obs_at(base + 6), obs_at(base + 7), obs_at(base + 9));
        end
        n  = obs_q.size() - base;
        ok = (n == exp_q.size());
        for (int i = 1; i < n; i++) if (obs_cyc[base + i] != obs_cyc[base] + i) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL b2b_gap: got %0d writes with a gap, want %0d gap-free", n, exp_q.size()); end
        checks++; if (idle_cnt - ib != 2) begin errors++; $display("FAIL b2b_busy_idle_cycles: got %0d want 2", idle_cnt - ib); end
        checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL b2b_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_stall();
        byte_q_t p;
        int base, d, v0, stall_w;
        do_reset();
        full_force = 1'b0;
        full_mode  = 3;
        @(posedge wclk);
        #1;
        base    = obs_q.size();
        v0      = viol;
        stall_w = 0;
        p = '{8'h55, 8'hAA};
        add_frame(p);
        fork
            send_packet(p, 1'b0);
            begin
                int n;
                n = 0;
                do begin
                    @(negedge wclk);
                    n++;
                end while (!(bus.winc === 1'b1 && bus.wdata === 8'hA5) && n < 100);
                // Applied right after the SYNC write, i.e. on the SEQ cycle.
                full_force = 1'b1;
                repeat (4) begin
                    @(negedge wclk);
                    if (bus.winc !== 1'b0) stall_w++;
                end
                full_force = 1'b0;
            end
        join
        wait_idle();
        full_mode = 0;
        d = first_diff(base);
        checks++; if (d >= 0) begin errors++;
            $display("FAIL stall_stream: idx %0d got %h want %h (got %0d bytes, want %0d)", d, obs_at(base + d), exp_at(d), obs_q.size() - base, exp_q.size());
        end
        checks++; if (stall_w != 0) begin errors++; $display("FAIL stall_winc: got %0d writes during stall want 0", stall_w); end
        checks++; if (obs_at(base + 4) !== 8'hFF || obs_q.size() - base != 5) begin errors++;
            $display("FAIL stall_csum: got %h (%0d bytes) want ff (5 bytes)", obs_at(base + 4), obs_q.size() - base);
        end
        checks++; if (viol != v0) begin errors++; $display("FAIL stall_full_violation: got %0d want 0", viol - v0); end
    endtask

    task automatic test_alternating();
        byte_q_t p;
        int base, d, v0;
        base = obs_q.size();
        v0   = viol;
        exp_q.delete();
        full_mode = 2;
        p = rand_payload(5);
        add_frame(p);
        send_packet(p, 1'b0);
        wait_idle();
        full_mode = 0;
        checks++; if (obs_q.size() - base != 8) begin errors++; $display("FAIL alt_write_count: got %0d want 8", obs_q.size() - base); end
        d = first_diff(base);
        checks++; if (d >= 0) begin errors++;
            $display("FAIL alt_stream: idx %0d got %h want %h", d, obs_at(base + d), exp_at(d));
        end
        checks++; if (viol != v0) begin errors++; $display("FAIL alt_full_violation: got %0d want 0", viol - v0); end
    endtask

    task automatic test_random();
        byte_q_t p;
        int base, d, v0;
        bit hold;
        base = obs_q.size();
        v0   = viol;
        exp_q.delete();
        full_mode = 1;
        for (int k = 0; k < 8; k++) begin
            p    = rand_payload($urandom_range(1, 8));
            hold = ($urandom_range(0, 1) == 1) && (k < 7);
            add_frame(p);
            send_packet(p, hold);
            if (!hold) repeat ($urandom_range(0, 4)) @(posedge wclk);
            #1;
        end
        wait_idle();
        full_mode = 0;
        d = first_diff(base);
        checks++; if (d >= 0) begin errors++;
            $display("FAIL rand_stream: idx %0d got %h want %h (got %0d bytes, want %0d)", d, obs_at(base + d), exp_at(d), obs_q.size() - base, exp_q.size());
        end
        checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL rand_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
        checks++; if (viol != v0) begin errors++; $display("FAIL rand_full_violation: got %0d want 0", viol - v0); end
    endtask

    task automatic test_reset_mid();
        byte_q_t p;
        int base, d, n;
        full_mode = 0;
        @(posedge wclk);
        #1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'(($urandom_range(0, 255)));
        bus.s_last  = 1'b0;
        n = 0;
        do begin
            @(negedge wclk);
            n++;
        end while (bus.s_ready !== 1'b1 && n < 50);
        repeat (2) @(negedge wclk);
        #2;
        wrst_n = 1'b0;
        #1;
        checks++; if (bus.winc !== 1'b0 || bus.wdata !== 8'h00 || bus.s_ready !== 1'b0) begin errors++;
            $display("FAIL midrst_outputs: got winc=%b wdata=%h s_ready=%b want 0 00 0", bus.winc, bus.wdata, bus.s_ready);
        end
        checks++; if (busy !== 1'b0 || frame_cnt !== 16'd0) begin errors++;
            $display("FAIL midrst_regs: got busy=%b frame_cnt=%0d want 0 0", busy, frame_cnt);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        exp_seq    = 0;
        exp_frames = 0;
        exp_q.delete();
        base = obs_q.size();
        p = rand_payload(3);
        add_frame(p);
        send_packet(p, 1'b0);
        wait_idle();
        d = first_diff(base);
        checks++; if (d >= 0) begin errors++;
            $display("FAIL midrst_stream: idx %0d got %h want %h", d, obs_at(base + d), exp_at(d));
        end
        checks++; if (obs_at(base) !== 8'hA5 || obs_at(base + 1) !== 8'h00) begin errors++;
            $display("FAIL midrst_header: got %h,%h want a5,00", obs_at(base), obs_at(base + 1));
        end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL midrst_frame_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_seq_wrap();
        byte_q_t p;
        int base, d;
        do_reset();
        base = obs_q.size();
        p = '{8'h00};
        for (int f = 0; f < 257; f++) begin
            add_frame(p);
            send_packet(p, f < 256);
        end
        wait_idle();
        d = first_diff(base);
        checks++; if (d >= 0) begin errors++;
            $display("FAIL wrap_stream: idx %0d got %h want %h (got %0d bytes, want %0d)", d, obs_at(base + d), exp_at(d), obs_q.size() - base, exp_q.size());
        end
        checks++; if (obs_at(base + 255 * 4 + 1) !== 8'hFF || obs_at(base + 255 * 4 + 3) !== 8'hFF) begin errors++;
            $display("FAIL wrap_frame256: got seq=%h csum=%h want ff ff", obs_at(base + 255 * 4 + 1), obs_at(base + 255 * 4 + 3));
        end
        checks++; if (obs_at(base + 256 * 4 + 1) !== 8'h00) begin errors++;
            $display("FAIL wrap_frame257_seq: got %h want 00", obs_at(base + 256 * 4 + 1));
        end
        checks++; if (frame_cnt !== 16'd257) begin errors++; $display("FAIL wrap_frame_cnt: got %0d want 257", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_alternating();
        test_random();
        test_reset_mid();
        test_seq_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_wr_framer
`default_nettype wire

// File: doc/fifo_wr_framer.md
# fifo_wr_framer

Write-domain framing stage that sits directly upstream of the asynchronous FIFO. It accepts a byte stream from the write-side producer, with valid/ready/last handshaking, and emits a framed byte sequence into the FIFO write port. Each frame is a sync byte, a sequence number, the payload bytes and an XOR checksum. Writes are throttled by the FIFO's `wfull`, so the read domain can find frame boundaries and detect corruption or loss.

## Interface
Parameters:
- `DSIZE`, 8: byte width; must match the FIFO data width.
- `SYNC`, 8'hA5: frame sync byte value.
- `CNTW`, 16: width of the `frame_cnt` output.

Ports:
- `wclk`  in  1: write-domain clock. All logic is on the rising edge.
- `wrst_n`  in  1: reset, asynchronous, active-low. Clock is `wclk`.
- `s_data`  in  DSIZE: payload byte from the producer.
- `s_valid`  in  1: `s_data` and `s_last` are valid.
- `s_last`  in  1: the current byte is the final payload byte of the packet.
- `s_ready`  out  1: the byte is consumed at this edge when `s_valid && s_ready`.
- `wfull`  in  1: FIFO full flag, registered in the FIFO.
- `winc`  out  1: FIFO write strobe. Never asserted while `wfull=1`.
- `wdata`  out  DSIZE: FIFO write data.
- `frame_cnt`  out  CNTW: number of completed frames. Wraps.
- `busy`  out  1: the state is not IDLE.

## Operation
- States: IDLE, SYNC, SEQ, DATA, CSUM. `state` is registered.
- A write is accepted at an edge where `winc=1`. Every transition out of SYNC, SEQ and CSUM requires an accepted write.
- **IDLE:** `winc=0`, `s_ready=0`, `wdata=0`. If `s_valid=1`, go to SYNC. The byte is not consumed.
- **SYNC:**
  - `wdata=SYNC`, `winc=!wfull`.
  - On write: `csum<=0`, go to SEQ.
- **SEQ:**
  - `wdata=seq`, `winc=!wfull`.
  - On write: `csum<=seq`, go to DATA.
- **DATA:**
  - `wdata=s_data`, `winc=s_valid&&!wfull`, `s_ready=!wfull`.
  - On write: `csum<=csum^s_data`.
  - If `s_last=1` on that write, go to CSUM.
- **CSUM:**
  - `wdata=csum`, `winc=!wfull`.
  - On write: `seq<=seq+1` (DSIZE bits, 255→0) and `frame_cnt<=frame_cnt+1` (wraps).
  - Next state is SYNC if `s_valid=1`, otherwise IDLE.
- `s_ready=0` in every state except DATA.
- Producer rules: while `s_valid && !s_ready`, `s_data` and `s_last` are held stable and `s_valid` is not withdrawn.
- A zero-length packet cannot occur: every packet carries at least one byte.
- `wfull=1` in any writing state: `winc=0`, `s_ready=0`, and the state, `csum` and `seq` hold. Resume on the first cycle with `wfull=0`.
- `wfull` toggling at every edge: each accepted write advances exactly one byte. No byte is duplicated or dropped.
- Reset asserted mid-frame: all registers clear immediately. The partial frame already in the FIFO stays there; the reader resynchronises on SYNC plus a checksum failure.
- Reset values: `state=IDLE`, `csum=0`, `seq=0`, `frame_cnt=0`. Outputs: `winc=0`, `wdata=0`, `s_ready=0`, `busy=0`.

## Timing
- `winc`, `wdata` and `s_ready` are combinational from `state`, `csum`, `seq`, `s_data`, `s_valid` and `wfull`. `frame_cnt` and `busy` are registered.
- The FIFO write at an edge is `winc && !wfull`. By construction this equals `winc`.
- Frame of N payload bytes, no stalls, starting from IDLE: 1 detect cycle, then N+3 consecutive write cycles.
- Back-to-back frames: the CSUM write is followed directly by the next frame's SYNC write, with no idle cycle. Throughput is N/(N+3).
- `frame_cnt` updates at the edge that accepts the CSUM write.
- `busy` drops one cycle after the final CSUM write only when no next packet is pending.

## Structure
- Shared package `fifo_frame_pkg`, also imported by the read-side deframer:
  - state enum;
  - `SYNC` default;
  - header length constant `HDR_LEN=2`;
  - checksum rule: XOR of `seq` and all payload bytes.
- Single flat module. No sub-module is warranted: one FSM, `csum`/`seq`/`frame_cnt` registers and an output mux.

## Test plan
- **Basic frame:** seq=0, payload 01,02,04 (last on 04), `wfull=0` → FIFO receives A5,00,01,02,04,07. `frame_cnt=1`. `s_ready` high only during the three DATA cycles.
- **Back-to-back frames:** frame 2 with payload 10 offered before frame 1's CSUM write → A5,01,10,11 follows 07 with zero gap. `frame_cnt=2`.
- **Stall:** `wfull=1` for 4 cycles starting during the SEQ write of frame A5,00,55,AA → `winc=0` throughout the stall. Output resumes with 00. Final stream is A5,00,55,AA,FF. No duplicate bytes.
- **Alternating full:** `wfull` alternates 1/0 per cycle over a 5-byte payload → exactly 8 writes. Checksum correct. `winc` never high with `wfull` high.
- **Sequence wrap:** 257 single-byte frames with payload 00 → the 256th frame carries seq FF and csum FF. The 257th carries seq 00. `frame_cnt=257`.
- **Reset mid-frame:** `wrst_n` pulsed low during the DATA state → outputs go to reset values asynchronously. The next packet produces A5,00,... with seq restarted at 0.
